rsa_modexp_param: RTL and testbench

- Parametrised modular-exponentiation engine computing result = message^exponent mod modulus.
- Successor to the fixed 32-bit RSA core. Adds a start/busy/done handshake, an error flag for degenerate moduli, and an operand width set by parameter.
- Uses a bit-serial interleaved modular multiplier (one multiplier bit per cycle), so there is no wide multiply or divide operator.
- Sits behind the crypto register interface; used for both RSA encrypt and decrypt.

---
 rtl/rsa_modexp_param.sv | 194 +++++++++++++++++++
 tb/tb_rsa_modexp_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_param.sv
// -----------------------------------------------------------------------------
// rsa_modexp_param
//
// Modular exponentiation engine: result = message^exponent mod modulus.
// It uses right-to-left square-and-multiply. Each modular product comes from
// a bit-serial interleaved multiplier that consumes one multiplier bit per
// cycle, so the design needs no wide multiplier or divider.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous, active-high reset; aborts any operation
//   start     in   request pulse, sampled only while idle
//   message   in   [WIDTH]      base operand, may be >= modulus
//   exponent  in   [EXP_WIDTH]  exponent
//   modulus   in   [WIDTH]      modulus n
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse, result valid from this cycle
//   result    out  [WIDTH]  last computed value, held until the next done
//   error     out  set with done when modulus < 2, held until next start
// -----------------------------------------------------------------------------
module rsa_modexp_param #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     message,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 error
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_CHECK,
    S_MUL,
    S_SQR
  } state_e;

  state_e                 state_q;
  logic [EXP_WIDTH-1:0]   exp_q;     // remaining exponent, shifted right per bit
  logic [WIDTH-1:0]       mod_q;
  logic [WIDTH-1:0]       acc_q;     // running product
  logic [WIDTH-1:0]       base_q;    // message^(2^k) mod n
  logic [WIDTH-1:0]       result_q;
  logic                   done_q;
  logic                   error_q;

  // Bit-serial multiplier state: a is consumed MSB-first by shifting left.
  logic [WIDTH-1:0]       mm_a_q;
  logic [WIDTH-1:0]       mm_b_q;
  logic [WIDTH-1:0]       mm_p_q;
  logic [CNT_W-1:0]       mm_cnt_q;

  // ---------------------------------------------------------------------------
  // One step of the interleaved multiplier. Because p < n and b < n hold, both
  // 2p and p+b stay below 2n, so a single conditional subtract restores the
  // invariant. One extra bit of headroom keeps these sums from wrapping.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mod_ext;
  logic [WIDTH:0]   mm_dbl;
  logic [WIDTH:0]   mm_dbl_red;
  logic [WIDTH:0]   mm_sum;
  logic [WIDTH-1:0] mm_p_d;
  logic             mm_last;

  assign mod_ext    = {1'b0, mod_q};
  assign mm_dbl     = {mm_p_q, 1'b0};
  assign mm_dbl_red = (mm_dbl >= mod_ext) ? (mm_dbl - mod_ext) : mm_dbl;
  assign mm_sum     = mm_a_q[WIDTH-1] ? (mm_dbl_red + {1'b0, mm_b_q}) : mm_dbl_red;
  assign mm_p_d     = (mm_sum >= mod_ext) ? WIDTH'(mm_sum - mod_ext) : WIDTH'(mm_sum);
  assign mm_last    = (mm_cnt_q == '0);

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge values of its peers, whatever order the statements appear in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_p_q   <= '0;
      mm_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            exp_q   <= exponent;
            mod_q   <= modulus;
            error_q <= 1'b0;
            // modulus < 2 means every bit above bit 0 is zero.
            if (modulus[WIDTH-1:1] == '0) begin
              result_q <= '0;
              error_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              // message * 1 mod n reduces the message into [0, n).
              acc_q    <= ONE;
              mm_a_q   <= message;
              mm_b_q   <= ONE;
              mm_p_q   <= '0;
              mm_cnt_q <= CNT_MAX;
              state_q  <= S_REDUCE;
            end
          end
        end

        S_REDUCE: begin
          if (mm_last) begin
            base_q  <= mm_p_d;
            state_q <= S_CHECK;
          end else begin
            mm_p_q   <= mm_p_d;
            mm_a_q   <= mm_a_q << 1;
            mm_cnt_q <= mm_cnt_q - 1'b1;
          end
        end

        S_CHECK: begin
          if (exp_q == '0) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end else if (exp_q[0]) begin
            mm_a_q   <= acc_q;
            mm_b_q   <= base_q;
            mm_p_q   <= '0;
            mm_cnt_q <= CNT_MAX;
            state_q  <= S_MUL;
          end else begin
            mm_a_q   <= base_q;
            mm_b_q   <= base_q;
            mm_p_q   <= '0;
            mm_cnt_q <= CNT_MAX;
            state_q  <= S_SQR;
          end
        end

        S_MUL: begin
          if (mm_last) begin
            // The square always follows the multiply for the same exponent bit.
            acc_q    <= mm_p_d;
            mm_a_q   <= base_q;
            mm_b_q   <= base_q;
            mm_p_q   <= '0;
            mm_cnt_q <= CNT_MAX;
            state_q  <= S_SQR;
          end else begin
            mm_p_q   <= mm_p_d;
            mm_a_q   <= mm_a_q << 1;
            mm_cnt_q <= mm_cnt_q - 1'b1;
          end
        end

        S_SQR: begin
          if (mm_last) begin
            base_q  <= mm_p_d;
            exp_q   <= exp_q >> 1;
            state_q <= S_CHECK;
          end else begin
            mm_p_q   <= mm_p_d;
            mm_a_q   <= mm_a_q << 1;
            mm_cnt_q <= mm_cnt_q - 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_param.sv
// -----------------------------------------------------------------------------
// tb_rsa_modexp_param
//
// Directed bench for rsa_modexp_param (WIDTH = EXP_WIDTH = 32). Each request
// pushes its expected result, error flag and start-to-done latency onto a
// scoreboard queue. The entry is popped and compared when done rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rsa_modexp_param;

  localparam int W   = 32;
  localparam int EW  = 32;
  localparam int MAX_EDGES = 5000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  message;
  logic [EW-1:0] exponent;
  logic [W-1:0]  modulus;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          error;

  rsa_modexp_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .message  (message),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .error    (error)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  t0    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: square-and-multiply using 64-bit products.
  function automatic logic [W-1:0] ref_modexp(logic [W-1:0] m, logic [EW-1:0] e,
                                              logic [W-1:0] n);
    logic [63:0]   r;
    logic [63:0]   b;
    logic [63:0]   n64;
    logic [EW-1:0] ee;
    if (n < 2) return '0;
    n64 = {32'b0, n};
    r   = 64'd1;
    b   = {32'b0, m} % n64;
    ee  = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % n64;
      b  = (b * b) % n64;
      ee = ee >> 1;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_latency(logic [EW-1:0] e, logic [W-1:0] n);
    int            lat;
    logic [EW-1:0] ee;
    if (n < 2) return 0;
    lat = W + 1;
    ee  = e;
    while (ee != 0) begin
      lat += 1 + W * (1 + int'(ee[0]));
      ee = ee >> 1;
    end
    return lat;
  endfunction

  // Entered and left on a falling edge. Drives one start pulse and returns at
  // the falling edge after the start edge.
  task automatic issue(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] n,
                       input logic [W-1:0] exp_res, input logic exp_err, input int exp_lat);
    sb_t s;
    s.res = exp_res;
    s.err = exp_err;
    s.lat = exp_lat;
    sb_q.push_back(s);
    message  = m;
    exponent = e;
    modulus  = n;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    t0       = edge_cnt;
  endtask

  task automatic issue_model(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] n);
    issue(m, e, n, ref_modexp(m, e, n), (n < 2), ref_latency(e, n));
  endtask

  // Waits for done within a bounded number of edges and compares the result
  // against the oldest scoreboard entry. Returns in the done cycle.
  task automatic wait_done(input string tag);
    sb_t  s;
    int   edges   = 0;
    logic busy_ok = 1'b1;
    while (!done && edges < MAX_EDGES) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    s = sb_q.pop_front();
    check({tag, "_result"},  64'(result), 64'(s.res));
    check({tag, "_error"},   64'(error),  64'(s.err));
    check({tag, "_latency"}, 64'(edge_cnt - t0), 64'(s.lat));
    check({tag, "_idle_at_done"}, 64'(busy), 64'd0);
    if (s.lat > 0) check({tag, "_busy_throughout"}, 64'(busy_ok), 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    message  = '0;
    exponent = '0;
    modulus  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_error",  64'(error),  64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Encrypt and decrypt round trip with the textbook RSA key
    issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, 262);
    wait_done("enc");
    @(negedge clk);
    issue(32'd2790, 32'd2753, 32'd3233, 32'd65, 1'b0, 589);
    wait_done("dec");
    @(negedge clk);

    // message >= modulus, single multiply
    issue(32'd4000, 32'd1, 32'd3233, 32'd767, 1'b0, 98);
    wait_done("msg_ge_mod");
    @(negedge clk);

    // Zero exponent
    issue(32'd123, 32'd0, 32'd3233, 32'd1, 1'b0, 33);
    wait_done("exp_zero");
    @(negedge clk);

    // Largest modulus: (-1)^2 mod n = 1 checks the extra headroom bit
    issue(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 131);
    wait_done("mod_max");
    @(negedge clk);

    // Zero message
    issue_model(32'd0, 32'd5, 32'd3233);
    wait_done("msg_zero");
    @(negedge clk);

    // Degenerate moduli, then a valid start clears the error flag
    issue(32'd77, 32'd3, 32'd1, 32'd0, 1'b1, 0);
    wait_done("mod_one");
    @(negedge clk);
    issue(32'd77, 32'd3, 32'd0, 32'd0, 1'b1, 0);
    wait_done("mod_zero");
    @(negedge clk);
    issue(32'd9, 32'd3, 32'd1000, 32'd729, 1'b0, 163);
    check("error_cleared_on_start", 64'(error), 64'd0);
    wait_done("after_err");
    @(negedge clk);

    // start while busy, with inputs changed mid-operation, must be ignored
    issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, 262);
    repeat (10) @(negedge clk);
    message  = 32'd5;
    exponent = 32'd3;
    modulus  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("busy_during_ignored_start", 64'(busy), 64'd1);
    wait_done("ignored_start");

    // start in the done cycle is accepted
    issue(32'd2790, 32'd2753, 32'd3233, 32'd65, 1'b0, 589);
    wait_done("back_to_back");
    @(negedge clk);

    // Random operands checked against the model
    for (int i = 0; i < 2; i++) begin
      issue_model($urandom, $urandom_range(1, 65535), $urandom | 32'h8000_0001);
      wait_done("random");
      @(negedge clk);
    end

    // Reset mid-SQR: 33 REDUCE/CHECK edges plus 32 MUL edges puts SQR from edge 66
    issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, 262);
    repeat (70) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(32'd4000, 32'd1, 32'd3233, 32'd767, 1'b0, 98);
    wait_done("after_abort");
    @(negedge clk);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
